// File: rtl/isp_color_pipe.sv
// isp_color_pipe: colour back-end (black level, white balance, 3x3 CCM) with
// valid/ready backpressure and per-frame configuration shadowing.
// Channel order on all RGB buses is {R,G,B}, R in the MSBs. cc_coeff entry k
// (row-major, k = row*3 + col, row = output channel) sits at bits [k*W +: W].
module isp_color_pipe #(
    parameter int PIXEL_WIDTH = 16,
    parameter int FRAC_BITS   = 6,
    parameter int INT_BITS    = 6
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [3*PIXEL_WIDTH-1:0]                in_rgb,
    input  logic                                    in_last,
    input  logic [3*PIXEL_WIDTH-1:0]                cblack,
    input  logic [3*(INT_BITS+FRAC_BITS)-1:0]       wb_gain,
    input  logic [9*(INT_BITS+FRAC_BITS)-1:0]       cc_coeff,
    input  logic                                    cc_bypass,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [3*PIXEL_WIDTH-1:0]                out_rgb,
    output logic                                    out_last,
    output logic                                    done
);

    localparam int PW  = PIXEL_WIDTH;
    localparam int GW  = INT_BITS + FRAC_BITS;
    localparam int MW  = PW + GW;          // unsigned WB product
    localparam int PRW = GW + PW + 1;      // signed CCM product
    localparam int SW  = PRW + 2;          // sum of three products
    localparam logic [MW-1:0]        WMAX = {{(MW - PW){1'b0}}, {PW{1'b1}}};
    localparam logic signed [SW-1:0] SMAX = {{(SW - PW){1'b0}}, {PW{1'b1}}};

    logic en;
    logic hs;
    logic cap;
    logic frame_start;

    logic [3*PW-1:0] sh_black;
    logic [3*GW-1:0] sh_gain;
    logic [9*GW-1:0] sh_coeff;
    logic            sh_bypass;

    logic [3*PW-1:0] eff_black;
    logic [3*GW-1:0] eff_gain;
    logic [9*GW-1:0] eff_coeff;
    logic            eff_bypass;

    logic [PW-1:0] ch_in  [3];
    logic [PW-1:0] ch_blk [3];
    logic [PW-1:0] d_c    [3];
    logic [MW-1:0] prod_c [3];
    logic [MW-1:0] shr_c  [3];
    logic [PW-1:0] w_next [3];

    // stage 1: white-balanced pixel plus the CCM config it must be corrected with
    logic          s1_valid;
    logic          s1_last;
    logic [PW-1:0] s1_w [3];
    logic [9*GW-1:0] s1_coeff;
    logic          s1_byp;

    logic signed [GW-1:0]  c_a    [9];
    logic signed [PW:0]    w_s    [3];
    logic signed [PRW-1:0] p_next [9];

    // stage 2: CCM products
    logic                  s2_valid;
    logic                  s2_last;
    logic signed [PRW-1:0] s2_p [9];
    logic [PW-1:0]         s2_w [3];
    logic                  s2_byp;

    logic signed [SW-1:0] sum_c [3];
    logic signed [SW-1:0] sft_c [3];
    logic [3*PW-1:0]      s3_rgb;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign hs       = in_valid && en;
    assign cap      = hs && frame_start;

    // first pixel of a frame sees the live config; the rest see the shadow copy
    always_comb begin
        eff_black  = cap ? cblack    : sh_black;
        eff_gain   = cap ? wb_gain   : sh_gain;
        eff_coeff  = cap ? cc_coeff  : sh_coeff;
        eff_bypass = cap ? cc_bypass : sh_bypass;
    end

    // frame tracking and config shadow capture
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b1;
            sh_black    <= '0;
            sh_gain     <= '0;
            sh_coeff    <= '0;
            sh_bypass   <= 1'b0;
        end else if (hs) begin
            if (frame_start) begin
                sh_black  <= cblack;
                sh_gain   <= wb_gain;
                sh_coeff  <= cc_coeff;
                sh_bypass <= cc_bypass;
            end
            frame_start <= in_last;
        end
    end

    // S1 math: black-level subtract with floor at 0, WB gain, saturate
    always_comb begin
        for (int unsigned j = 0; j < 3; j++) begin
            ch_in[j]  = in_rgb[(2 - j) * PW +: PW];
            ch_blk[j] = eff_black[(2 - j) * PW +: PW];
            d_c[j]    = (ch_in[j] > ch_blk[j]) ? (ch_in[j] - ch_blk[j]) : '0;
            prod_c[j] = MW'(d_c[j]) * MW'(eff_gain[(2 - j) * GW +: GW]);
            shr_c[j]  = prod_c[j] >> FRAC_BITS;
            w_next[j] = (shr_c[j] > WMAX) ? '1 : shr_c[j][PW-1:0];
        end
    end

    // S2 math: nine full-width signed products
    always_comb begin
        for (int unsigned j = 0; j < 3; j++) begin
            w_s[j] = $signed({1'b0, s1_w[j]});
        end
        for (int unsigned k = 0; k < 9; k++) begin
            c_a[k]    = $signed(s1_coeff[k * GW +: GW]);
            p_next[k] = PRW'(c_a[k]) * PRW'(w_s[k % 3]);
        end
    end

    // S3 math: row sums, arithmetic shift, clamp to [0, max]; bypass picks WB result
    always_comb begin
        s3_rgb = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum_c[i] = SW'(s2_p[i * 3]) + SW'(s2_p[i * 3 + 1]) + SW'(s2_p[i * 3 + 2]);
            sft_c[i] = sum_c[i] >>> FRAC_BITS;
            if (s2_byp) begin
                s3_rgb[(2 - i) * PW +: PW] = s2_w[i];
            end else if (sft_c[i] < 0) begin
                s3_rgb[(2 - i) * PW +: PW] = '0;
            end else if (sft_c[i] > SMAX) begin
                s3_rgb[(2 - i) * PW +: PW] = '1;
            end else begin
                s3_rgb[(2 - i) * PW +: PW] = sft_c[i][PW-1:0];
            end
        end
    end

    // pipeline control: valids, sideband last and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_rgb   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_last   <= in_valid && in_last;
            s2_valid  <= s1_valid;
            s2_last   <= s1_valid && s1_last;
            out_valid <= s2_valid;
            out_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                out_rgb <= s3_rgb;
            end
        end
    end

    // pipeline datapath registers, held while stalled
    always_ff @(posedge clk) begin
        if (en) begin
            s1_w     <= w_next;
            s1_coeff <= eff_coeff;
            s1_byp   <= eff_bypass;
            s2_p     <= p_next;
            s2_w     <= s1_w;
            s2_byp   <= s1_byp;
        end
    end

    // end-of-frame pulse, one cycle after the last pixel leaves
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= out_valid && out_ready && out_last;
        end
    end

endmodule

// File: tb/tb_isp_color_pipe.sv
// Directed self-checking bench for isp_color_pipe (16-bit pixels, Q6.6 gains/coeffs).
module tb_isp_color_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [47:0]  in_rgb;
    logic         in_last;
    logic [47:0]  cblack;
    logic [35:0]  wb_gain;
    logic [107:0] cc_coeff;
    logic         cc_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [47:0]  out_rgb;
    logic         out_last;
    logic         done;

    int vec  = 0;
    int miss = 0;

    isp_color_pipe #(.PIXEL_WIDTH(16), .FRAC_BITS(6), .INT_BITS(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .in_last(in_last),
        .cblack(cblack), .wb_gain(wb_gain), .cc_coeff(cc_coeff), .cc_bypass(cc_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rgb(input int r, input int g, input int b);
        return {r[15:0], g[15:0], b[15:0]};
    endfunction

    function automatic logic [35:0] gains(input int r, input int g, input int b);
        return {r[11:0], g[11:0], b[11:0]};
    endfunction

    task automatic set_ccm(input int c0, input int c1, input int c2,
                           input int c3, input int c4, input int c5,
                           input int c6, input int c7, input int c8);
        int c [9];
        c = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
        for (int k = 0; k < 9; k++) begin
            cc_coeff[k * 12 +: 12] = c[k][11:0];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one-pixel transaction with out_ready high; returns the output pixel
    task automatic send_one(input logic [47:0] px, input logic last, output logic [47:0] got);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_rgb = px; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        got = out_rgb;
    endtask

    logic [47:0] got;
    logic [47:0] exp_q [10];
    int          seen_cyc [$];
    logic [47:0] seen_px  [$];
    int          idx, nout, done_cnt;
    logic        prev_last_hs, hs_out, stall_seen;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rgb = '0; in_last = 1'b0;
        out_ready = 1'b1; cblack = '0; wb_gain = gains(64, 64, 64);
        cc_coeff = '0; cc_bypass = 1'b0;
        set_ccm(64, 0, 0, 0, 64, 0, 0, 0, 64);
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_rgb", {16'd0, out_rgb}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;

        // 1: identity, latency exactly 3 cycles
        @(negedge clk);
        in_valid = 1'b1; in_rgb = rgb(100, 200, 300); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("lat_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_c2", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_c3", {63'd0, out_valid}, 64'd1);
        chk("ident_px", {16'd0, out_rgb}, {16'd0, rgb(100, 200, 300)});
        repeat (3) @(negedge clk);

        // 1b: 4-pixel burst -> 4 consecutive output cycles
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen_cyc.push_back(c);
                seen_px.push_back(out_rgb);
            end
            in_valid = (c < 4);
            in_rgb   = rgb(c * 10 + 1, c * 10 + 2, c * 10 + 3);
            in_last  = (c == 3);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("burst_count", 64'(seen_cyc.size()), 64'd4);
        if (seen_cyc.size() == 4) begin
            chk("burst_consec", 64'(seen_cyc[3] - seen_cyc[0]), 64'd3);
            for (int k = 0; k < 4; k++) begin
                chk("burst_px", {16'd0, seen_px[k]}, {16'd0, rgb(k * 10 + 1, k * 10 + 2, k * 10 + 3)});
            end
        end

        // 2: black level
        cblack = rgb(20, 0, 0);
        send_one(rgb(10, 7, 9), 1'b1, got);
        chk("black_clamp", {16'd0, got}, {16'd0, rgb(0, 7, 9)});
        send_one(rgb(50, 7, 9), 1'b1, got);
        chk("black_sub", {16'd0, got}, {16'd0, rgb(30, 7, 9)});
        cblack = '0;

        // 3: white balance
        wb_gain = gains(4032, 64, 64);
        send_one(rgb(2000, 5, 6), 1'b1, got);
        chk("wb_sat", {16'd0, got}, {16'd0, rgb(65535, 5, 6)});
        wb_gain = gains(96, 64, 64);
        send_one(rgb(100, 5, 6), 1'b1, got);
        chk("wb_gain", {16'd0, got}, {16'd0, rgb(150, 5, 6)});
        wb_gain = gains(64, 64, 64);

        // 4: CCM clamps and bypass
        set_ccm(64, -128, 0, 0, 64, 0, 0, 0, 64);
        send_one(rgb(100, 100, 0), 1'b1, got);
        chk("ccm_neg", {16'd0, got}, {16'd0, rgb(0, 100, 0)});
        set_ccm(64, 64, 64, 0, 64, 0, 0, 0, 64);
        send_one(rgb(30000, 30000, 30000), 1'b1, got);
        chk("ccm_sat", {16'd0, got}, {16'd0, rgb(65535, 30000, 30000)});
        send_one(rgb(100, 200, 300), 1'b1, got);
        chk("ccm_mix", {16'd0, got}, {16'd0, rgb(600, 200, 300)});
        cc_bypass = 1'b1; wb_gain = gains(96, 64, 64);
        send_one(rgb(1000, 2000, 3000), 1'b1, got);
        chk("ccm_bypass", {16'd0, got}, {16'd0, rgb(1500, 2000, 3000)});
        cc_bypass = 1'b0; wb_gain = gains(64, 64, 64);
        set_ccm(64, 0, 0, 0, 64, 0, 0, 0, 64);
        repeat (3) @(negedge clk);

        // 5: 10-pixel stream with a 5-cycle output stall
        for (int k = 0; k < 10; k++) exp_q[k] = rgb(k * 100 + 1, k * 100 + 2, k * 100 + 3);
        idx = 0; nout = 0; done_cnt = 0; prev_last_hs = 1'b0; stall_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (idx < 10);
            in_rgb    = rgb(idx * 100 + 1, idx * 100 + 2, idx * 100 + 3);
            in_last   = (idx == 9);
            #1;
            chk("stream_done", {63'd0, done}, {63'd0, prev_last_hs});
            chk("stream_in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (out_valid && !out_ready) stall_seen = 1'b1;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (nout < 10) begin
                    chk("stream_px", {16'd0, out_rgb}, {16'd0, exp_q[nout]});
                    chk("stream_last", {63'd0, out_last}, {63'd0, (nout == 9)});
                end
                nout++;
            end
            prev_last_hs = hs_out && out_last;
            if (done) done_cnt++;
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        chk("stream_in_count", 64'(idx), 64'd10);
        chk("stream_out_count", 64'(nout), 64'd10);
        chk("stream_done_count", 64'(done_cnt), 64'd1);
        chk("stream_stall_seen", {63'd0, stall_seen}, 64'd1);

        // 6: mid-frame config change is ignored until next frame
        wb_gain = gains(64, 64, 64);
        send_one(rgb(100, 200, 300), 1'b0, got);
        chk("shadow_a", {16'd0, got}, {16'd0, rgb(100, 200, 300)});
        wb_gain = gains(128, 64, 64);
        send_one(rgb(100, 200, 300), 1'b1, got);
        chk("shadow_b", {16'd0, got}, {16'd0, rgb(100, 200, 300)});
        send_one(rgb(100, 200, 300), 1'b0, got);
        chk("shadow_c", {16'd0, got}, {16'd0, rgb(200, 200, 300)});

        // 6b: reset mid-frame flushes the pipe and restarts the frame
        wb_gain = gains(192, 64, 64);
        @(negedge clk);
        in_valid = 1'b1; in_rgb = rgb(100, 200, 300); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst_flush_valid", {63'd0, out_valid}, 64'd0);
            chk("midrst_flush_done", {63'd0, done}, 64'd0);
        end
        send_one(rgb(100, 200, 300), 1'b1, got);
        chk("midrst_newcfg", {16'd0, got}, {16'd0, rgb(300, 200, 300)});

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
